// File: rtl/nibble_rx_pkg.sv
// nibble_rx shared types: FSM states, frame geometry, mid-bit offset helper.
// Optional even-parity bit is enabled with NIBBLE_RX_PARITY_EN.
package nibble_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int DATA_BITS = 4;

    function automatic int half_of(input int bit_cycles);
        return (bit_cycles - 1) / 2;
    endfunction

endpackage

// File: rtl/nibble_rx_if.sv
// Valid/ready bundle between nibble_rx and the classifier consumer.
// master drives the nibble, slave returns ready.
interface nibble_rx_if;
    import nibble_rx_pkg::*;

    logic [DATA_BITS-1:0] x;
    logic                 x_valid;
    logic                 x_ready;

    modport master (
        output x,
        output x_valid,
        input  x_ready
    );

    modport slave (
        input  x,
        input  x_valid,
        output x_ready
    );

endinterface

// File: rtl/nibble_rx_bit_timer.sv
// Bit-period timer: one-cycle tick HALF clocks after start, then every
// BIT_CYCLES clocks until aborted.
module nibble_rx_bit_timer
    import nibble_rx_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic tick
);

    localparam int HALF = half_of(BIT_CYCLES);
    localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);
    // With no mid-bit offset the start edge is itself the first sample.
    localparam logic [7:0] FIRST = (HALF == 0) ? RELOAD : 8'(HALF - 1);

    logic [7:0] cnt;
    logic       run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= 8'd0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= FIRST;
        end else if (abort) begin
            run <= 1'b0;
            cnt <= 8'd0;
        end else if (run) begin
            cnt <= (cnt == 8'd0) ? RELOAD : cnt - 8'd1;
        end
    end

    assign tick = run && (cnt == 8'd0);

endmodule

// File: rtl/nibble_rx.sv
// Framed serial nibble receiver with one-entry valid/ready holding register.
// Define NIBBLE_RX_PARITY_EN to expect an even parity bit before stop.
module nibble_rx
    import nibble_rx_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          err_clr,
    nibble_rx_if.master   bus,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun,
    output logic          busy
);

    localparam int HALF = half_of(BIT_CYCLES);
    localparam logic [1:0] LAST = 2'(DATA_BITS - 1);

    state_t               state;
    state_t               state_n;
    logic                 tick;
    logic                 start;
    logic                 abort;
    logic                 shift_en;
    logic                 stop_en;
    logic                 bad;
    logic                 deliver;
    logic                 load;
    logic [1:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] x_q;
    logic                 x_valid_q;

    assign start = (state == IDLE) && !din;
    assign abort = (state_n == IDLE) || (state_n == WAIT_HIGH);

    nibble_rx_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (!din) state_n = (HALF == 0) ? DATA : START;
            START:     if (tick) state_n = din ? IDLE : DATA;
            DATA: begin
                if (tick && bit_idx == LAST) begin
`ifdef NIBBLE_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
            PARITY:    if (tick) state_n = STOP;
            STOP:      if (tick) state_n = din ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (din)  state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

`ifdef NIBBLE_RX_PARITY_EN
    logic par_en;
    logic par_fail;
`endif

    always_comb begin
        shift_en = 1'b0;
        stop_en  = 1'b0;
        busy     = 1'b1;
`ifdef NIBBLE_RX_PARITY_EN
        par_en   = 1'b0;
`endif
        unique case (1'b1)
            state == IDLE:   busy     = 1'b0;
            state == DATA:   shift_en = tick;
`ifdef NIBBLE_RX_PARITY_EN
            state == PARITY: par_en   = tick;
`endif
            state == STOP:   stop_en  = tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= 2'd0;
        end else begin
            if (state == IDLE) bit_idx <= 2'd0;
            if (shift_en) begin
                shreg   <= {shreg[DATA_BITS-2:0], din};
                bit_idx <= bit_idx + 2'd1;
            end
        end
    end

`ifdef NIBBLE_RX_PARITY_EN
    assign par_fail = par_en && (^{shreg, din});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad        <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == IDLE) bad <= 1'b0;
            if (par_fail)      bad <= 1'b1;
            parity_err <= (parity_err && !err_clr) || par_fail;
        end
    end
`else
    assign bad        = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign deliver = stop_en && din && !bad;
    assign load    = deliver && (!x_valid_q || bus.x_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            x_valid_q <= 1'b0;
        end else if (load) begin
            x_q       <= shreg;
            x_valid_q <= 1'b1;
        end else if (x_valid_q && bus.x_ready) begin
            x_valid_q <= 1'b0;
        end
    end

    // Set wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err && !err_clr) || (stop_en && !din);
            overrun   <= (overrun && !err_clr) ||
                         (deliver && x_valid_q && !bus.x_ready);
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;

endmodule

// File: tb/tb_nibble_rx.sv
// Directed bench for nibble_rx at BIT_CYCLES=4.
// Frames carry a parity bit only when NIBBLE_RX_PARITY_EN is defined.
module tb_nibble_rx;

    localparam int BC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic din = 1'b1;
    logic err_clr = 1'b0;
    logic x_ready = 1'b1;
    logic frame_err;
    logic parity_err;
    logic overrun;
    logic busy;

    int checks = 0;
    int errors = 0;

`ifdef NIBBLE_RX_PARITY_EN
    logic flip_par = 1'b0;
`endif

    nibble_rx_if bus ();
    assign bus.x_ready = x_ready;

    nibble_rx #(
        .BIT_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .err_clr   (err_clr),
        .bus       (bus),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves us #1 after the stop-sample edge, din still at the stop level.
    task automatic send_frame(input logic [3:0] nib, input logic stop,
                              input logic stop_rdy);
        din = 1'b0;
        cyc(BC);
        for (int i = 3; i >= 0; i--) begin
            din = nib[i];
            cyc(BC);
        end
`ifdef NIBBLE_RX_PARITY_EN
        din = (^nib) ^ flip_par;
        cyc(BC);
`endif
        din = stop;
        cyc(1);
        x_ready = stop_rdy;
        cyc(1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        cyc(2);
        check("rst_x", 8'(bus.x), 8'h0);
        check("rst_valid", 8'(bus.x_valid), 8'h0);
        check("rst_ferr", 8'(frame_err), 8'h0);
        check("rst_perr", 8'(parity_err), 8'h0);
        check("rst_ovr", 8'(overrun), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        rst_n = 1'b1;
        cyc(2);

        send_frame(4'b0110, 1'b1, 1'b1);
        check("t1_x", 8'(bus.x), 8'h6);
        check("t1_valid", 8'(bus.x_valid), 8'h1);
        check("t1_busy", 8'(busy), 8'h0);
        cyc(1);
        check("t1_consumed", 8'(bus.x_valid), 8'h0);
        check("t1_ferr", 8'(frame_err), 8'h0);
        check("t1_perr", 8'(parity_err), 8'h0);
        check("t1_ovr", 8'(overrun), 8'h0);
        cyc(2);

`ifdef NIBBLE_RX_PARITY_EN
        flip_par = 1'b1;
        send_frame(4'b1001, 1'b1, 1'b1);
        flip_par = 1'b0;
        check("par_err", 8'(parity_err), 8'h1);
        check("par_x", 8'(bus.x), 8'h6);
        check("par_valid", 8'(bus.x_valid), 8'h0);
        cyc(2);
        pulse_clr();
        check("par_clr", 8'(parity_err), 8'h0);
`endif

        send_frame(4'b0011, 1'b0, 1'b1);
        check("fe_set", 8'(frame_err), 8'h1);
        check("fe_x", 8'(bus.x), 8'h6);
        check("fe_valid", 8'(bus.x_valid), 8'h0);
        check("fe_busy", 8'(busy), 8'h1);
        cyc(10);
        check("fe_wait_busy", 8'(busy), 8'h1);
        check("fe_wait_valid", 8'(bus.x_valid), 8'h0);
        din = 1'b1;
        cyc(1);
        check("fe_idle", 8'(busy), 8'h0);
        pulse_clr();
        check("fe_clr", 8'(frame_err), 8'h0);
        cyc(2);

        x_ready = 1'b0;
        send_frame(4'b0111, 1'b1, 1'b0);
        check("ov_first_x", 8'(bus.x), 8'h7);
        check("ov_first_valid", 8'(bus.x_valid), 8'h1);
        cyc(2);
        send_frame(4'b1010, 1'b1, 1'b0);
        check("ov_x_kept", 8'(bus.x), 8'h7);
        check("ov_valid", 8'(bus.x_valid), 8'h1);
        check("ov_set", 8'(overrun), 8'h1);
        cyc(2);
        pulse_clr();
        check("ov_clr", 8'(overrun), 8'h0);
        send_frame(4'b1010, 1'b1, 1'b1);
        check("rl_x", 8'(bus.x), 8'hA);
        check("rl_valid", 8'(bus.x_valid), 8'h1);
        check("rl_ovr", 8'(overrun), 8'h0);
        cyc(1);
        check("rl_consumed", 8'(bus.x_valid), 8'h0);
        x_ready = 1'b0;
        cyc(2);

        din = 1'b0;
        cyc(1);
        din = 1'b1;
        check("fs_busy", 8'(busy), 8'h1);
        cyc(1);
        check("fs_idle", 8'(busy), 8'h0);
        check("fs_valid", 8'(bus.x_valid), 8'h0);
        check("fs_ferr", 8'(frame_err), 8'h0);
        check("fs_perr", 8'(parity_err), 8'h0);
        check("fs_ovr", 8'(overrun), 8'h0);
        cyc(4);

        din = 1'b0;
        cyc(BC);
        din = 1'b1;
        cyc(3);
        check("mr_busy", 8'(busy), 8'h1);
        rst_n = 1'b0;
        #1;
        check("mr_x", 8'(bus.x), 8'h0);
        check("mr_valid", 8'(bus.x_valid), 8'h0);
        check("mr_busy0", 8'(busy), 8'h0);
        check("mr_ferr", 8'(frame_err), 8'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        send_frame(4'b1011, 1'b1, 1'b0);
        check("mr_new_x", 8'(bus.x), 8'hB);
        check("mr_new_valid", 8'(bus.x_valid), 8'h1);
        check("mr_new_ferr", 8'(frame_err), 8'h0);
        check("mr_new_ovr", 8'(overrun), 8'h0);
        cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
